ghost_mover: RTL and testbench

Parametrised ghost movement engine, successor to the fixed per-colour ghost blocks; one instance per ghost, distinguished only by parameters. Runs on the system clock, with frame_clk and sec sampled as enables. Adds buffered turn requests, same-tick motion/position update, home-release delay, a frightened mode at half speed with blink warning, and eaten/respawn handling. Feeds sprite rendering and collision logic with position, size, direction and mode.

---
 rtl/ghost_pkg.sv | 44 ++++
 rtl/ghost_mover_tick_sync.sv | 27 ++
 rtl/ghost_mover.sv | 181 ++++++++++++++++++
 tb/tb_ghost_mover.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// Shared types and helpers for the ghost movement engine.
package ghost_pkg;

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_L    = 3'd1,
    DIR_R    = 3'd2,
    DIR_D    = 3'd3,
    DIR_U    = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    MODE_HOME    = 2'd0,
    MODE_ROAM    = 2'd1,
    MODE_FRIGHT  = 2'd2,
    MODE_RESPAWN = 2'd3
  } mode_t;

  localparam logic [7:0] KEY_L = 8'h07;
  localparam logic [7:0] KEY_R = 8'h16;
  localparam logic [7:0] KEY_D = 8'h1A;
  localparam logic [7:0] KEY_U = 8'h04;

  function automatic dir_t reverse_dir(input dir_t d);
    case (d)
      DIR_L:   return DIR_R;
      DIR_R:   return DIR_L;
      DIR_D:   return DIR_U;
      DIR_U:   return DIR_D;
      default: return DIR_NONE;
    endcase
  endfunction

  function automatic dir_t decode_key(input logic [7:0] k);
    case (k)
      KEY_L:   return DIR_L;
      KEY_R:   return DIR_R;
      KEY_D:   return DIR_D;
      KEY_U:   return DIR_U;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ghost_mover_tick_sync.sv
// Two-flop synchroniser with registered rising-edge pulse (one clock wide).
module tick_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_tick
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      o_tick  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      o_tick  <= r_sync2 & ~r_prev;
    end
  end

endmodule

// File: rtl/ghost_mover.sv
// Per-ghost movement engine: buffered turns, tunnel wrap, home/fright/respawn modes.
module ghost_mover
  import ghost_pkg::*;
#(
  parameter int unsigned X_CENTER     = 204,
  parameter int unsigned Y_CENTER     = 80,
  parameter int unsigned SIZE         = 13,
  parameter int unsigned X_MIN        = 7,
  parameter int unsigned X_MAX        = 396,
  parameter int unsigned Y_MIN        = 7,
  parameter int unsigned Y_MAX        = 440,
  parameter int unsigned STEP         = 1,
  parameter int unsigned RELEASE_SECS = 2,
  parameter int unsigned RESPAWN_SECS = 3,
  parameter int unsigned FRIGHT_SECS  = 6,
  parameter int unsigned BLINK_SECS   = 2,
  parameter int unsigned TUN_Y_MIN    = 195,
  parameter int unsigned TUN_Y_MAX    = 223,
  parameter int unsigned TUN_L_X      = 10,
  parameter int unsigned TUN_R_X      = 390,
  parameter int unsigned TUN_L_DEST   = 15,
  parameter int unsigned TUN_R_DEST   = 385
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       sec,
  input  logic       pause,
  input  logic       fright_req,
  input  logic       eaten,
  input  logic [7:0] dir_code,
  input  logic [4:0] mapL,
  input  logic [4:0] mapR,
  input  logic [4:0] mapB,
  input  logic [4:0] mapT,
  output logic [9:0] ghostX,
  output logic [9:0] ghostY,
  output logic [9:0] ghostS,
  output logic [2:0] dir,
  output logic [1:0] mode,
  output logic       blink
);

  // x-SIZE > X_MIN rewritten as x > X_MIN+SIZE so nothing can underflow
  localparam logic [10:0] L_LIM = 11'(X_MIN + SIZE);
  localparam logic [10:0] U_LIM = 11'(Y_MIN + SIZE);

  logic       w_tick_f, w_tick_s;
  dir_t       w_key, w_next_dir;
  logic       w_band, w_open_l, w_open_r, w_open_d, w_open_u;
  logic       w_adopt, w_wrap_l, w_wrap_r, w_eat, w_fright, w_move;
  logic [9:0] w_next_x, w_next_y;

  mode_t      r_mode;
  dir_t       r_dir, r_pend;
  logic [9:0] r_x, r_y;
  logic [7:0] r_timer;
  logic       r_toggle, r_blink;

  tick_sync u_sync_f (.i_clk(Clk), .i_rst_n(Reset_n), .i_async(frame_clk), .o_tick(w_tick_f));
  tick_sync u_sync_s (.i_clk(Clk), .i_rst_n(Reset_n), .i_async(sec),       .o_tick(w_tick_s));

  function automatic logic open_sel(input dir_t d, input logic l, input logic r,
                                    input logic dn, input logic u);
    case (d)
      DIR_L:   return l;
      DIR_R:   return r;
      DIR_D:   return dn;
      DIR_U:   return u;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    w_key  = decode_key(dir_code);
    w_band = (r_y >= 10'(TUN_Y_MIN)) && (r_y <= 10'(TUN_Y_MAX));
    // Horizontal borders are waived inside the tunnel row so the ghost can reach the wrap triggers.
    w_open_l = (mapL == '0) && (w_band || ({1'b0, r_x} > L_LIM));
    w_open_r = (mapR == '0) && (w_band || (({1'b0, r_x} + 11'(SIZE)) < 11'(X_MAX)));
    w_open_d = (mapB == '0) && (({1'b0, r_y} + 11'(SIZE)) < 11'(Y_MAX));
    w_open_u = (mapT == '0) && ({1'b0, r_y} > U_LIM);
    w_adopt  = (r_pend != DIR_NONE) && open_sel(r_pend, w_open_l, w_open_r, w_open_d, w_open_u);
    if (w_adopt)
      w_next_dir = r_pend;
    else if (open_sel(r_dir, w_open_l, w_open_r, w_open_d, w_open_u))
      w_next_dir = r_dir;
    else
      w_next_dir = DIR_NONE;
    w_wrap_l = w_band && (r_x <= 10'(TUN_L_X));
    w_wrap_r = w_band && (r_x >= 10'(TUN_R_X));
    w_next_x = r_x;
    w_next_y = r_y;
    if (w_wrap_l)
      w_next_x = 10'(TUN_R_DEST);
    else if (w_wrap_r)
      w_next_x = 10'(TUN_L_DEST);
    else begin
      case (w_next_dir)
        DIR_L:   w_next_x = r_x - 10'(STEP);
        DIR_R:   w_next_x = r_x + 10'(STEP);
        DIR_D:   w_next_y = r_y + 10'(STEP);
        DIR_U:   w_next_y = r_y - 10'(STEP);
        default: ;
      endcase
    end
    w_eat    = eaten && (r_mode == MODE_FRIGHT);
    w_fright = fright_req && ((r_mode == MODE_ROAM) || (r_mode == MODE_FRIGHT));
    w_move   = w_tick_f && ((r_mode == MODE_ROAM) || ((r_mode == MODE_FRIGHT) && r_toggle));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_mode   <= MODE_HOME;
      r_x      <= 10'(X_CENTER);
      r_y      <= 10'(Y_CENTER);
      r_dir    <= DIR_NONE;
      r_pend   <= DIR_NONE;
      r_blink  <= 1'b0;
      r_timer  <= 8'(RELEASE_SECS);
      r_toggle <= 1'b0;
    end else if (!pause) begin
      if (w_key != DIR_NONE) r_pend <= w_key;
      if (w_eat) begin
        r_mode  <= MODE_RESPAWN;
        r_x     <= 10'(X_CENTER);
        r_y     <= 10'(Y_CENTER);
        r_dir   <= DIR_NONE;
        r_pend  <= DIR_NONE;
        r_blink <= 1'b0;
        r_timer <= 8'(RESPAWN_SECS);
      end else if (w_fright) begin
        // A mode request swallows any coincident frame tick.
        if (r_mode == MODE_ROAM) begin
          r_dir    <= reverse_dir(r_dir);
          r_toggle <= 1'b0;
        end
        r_mode  <= MODE_FRIGHT;
        r_timer <= 8'(FRIGHT_SECS);
        r_blink <= 1'b0;
      end else begin
        if (w_tick_s) begin
          case (r_mode)
            MODE_HOME, MODE_RESPAWN: begin
              if (r_timer < 8'd2) begin
                r_mode <= MODE_ROAM;
                r_dir  <= DIR_NONE;
              end else r_timer <= r_timer - 8'd1;
            end
            MODE_FRIGHT: begin
              if (r_timer < 8'd2) begin
                r_mode  <= MODE_ROAM;
                r_blink <= 1'b0;
              end else begin
                r_timer <= r_timer - 8'd1;
                r_blink <= (r_timer - 8'd1) <= 8'(BLINK_SECS);
              end
            end
            default: ;
          endcase
        end
        if (w_tick_f && (r_mode == MODE_FRIGHT)) r_toggle <= ~r_toggle;
        if (w_move) begin
          r_x <= w_next_x;
          r_y <= w_next_y;
          if (!w_wrap_l && !w_wrap_r) begin
            r_dir <= w_next_dir;
            if (w_adopt && (w_key == DIR_NONE)) r_pend <= DIR_NONE;
          end
        end
      end
    end
  end

  assign ghostX = r_x;
  assign ghostY = r_y;
  assign ghostS = 10'(SIZE);
  assign dir    = r_dir;
  assign mode   = r_mode;
  assign blink  = r_blink;

endmodule

// File: tb/tb_ghost_mover.sv
// Directed and randomized checks of ghost_mover against an event-level reference model.
module tb_ghost_mover;

  localparam int XC = 204, YC = 80, SZ = 13;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0, sec = 1'b0, pause = 1'b0;
  logic       fright_req = 1'b0, eaten = 1'b0;
  logic [7:0] dir_code = 8'h00;
  logic [4:0] mapL = '0, mapR = '0, mapB = '0, mapT = '0;
  logic [9:0] ghostX, ghostY, ghostS;
  logic [2:0] dir;
  logic [1:0] mode;
  logic       blink;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: mode 0 HOME,1 ROAM,2 FRIGHT,3 RESPAWN; dir 0 none,1 L,2 R,3 D,4 U
  int m_mode, m_x, m_y, m_dir, m_pend, m_timer, m_blink;
  bit m_tog;

  ghost_mover dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .sec(sec), .pause(pause),
    .fright_req(fright_req), .eaten(eaten), .dir_code(dir_code),
    .mapL(mapL), .mapR(mapR), .mapB(mapB), .mapT(mapT),
    .ghostX(ghostX), .ghostY(ghostY), .ghostS(ghostS), .dir(dir), .mode(mode), .blink(blink)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".x"},     32'(ghostX), 32'(m_x));
    chk({tag, ".y"},     32'(ghostY), 32'(m_y));
    chk({tag, ".dir"},   32'(dir),    32'(m_dir));
    chk({tag, ".mode"},  32'(mode),   32'(m_mode));
    chk({tag, ".blink"}, 32'(blink),  32'(m_blink));
    chk({tag, ".size"},  32'(ghostS), 32'(SZ));
  endtask

  function automatic int key_dir(input logic [7:0] k);
    case (k)
      8'h07: return 1;
      8'h16: return 2;
      8'h1A: return 3;
      8'h04: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit in_band();
    return (m_y >= 195) && (m_y <= 223);
  endfunction

  function automatic bit is_open(input int d);
    case (d)
      1: return (mapL == 0) && (in_band() || (m_x - SZ > 7));
      2: return (mapR == 0) && (in_band() || (m_x + SZ < 396));
      3: return (mapB == 0) && (m_y + SZ < 440);
      4: return (mapT == 0) && (m_y - SZ > 7);
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    m_mode = 0; m_x = XC; m_y = YC; m_dir = 0; m_pend = 0;
    m_timer = 2; m_blink = 0; m_tog = 0;
  endtask

  task automatic m_frame();
    bit go;
    if (pause) return;
    go = (m_mode == 1);
    if (m_mode == 2) begin
      go = m_tog;
      m_tog = !m_tog;
    end
    if (!go) return;
    if (in_band() && m_x <= 10) m_x = 385;
    else if (in_band() && m_x >= 390) m_x = 15;
    else begin
      if (m_pend != 0 && is_open(m_pend)) begin
        m_dir = m_pend;
        m_pend = 0;
      end else if (!is_open(m_dir)) m_dir = 0;
      case (m_dir)
        1: m_x -= 1;
        2: m_x += 1;
        3: m_y += 1;
        4: m_y -= 1;
        default: ;
      endcase
    end
  endtask

  task automatic m_second();
    if (pause || m_mode == 1) return;
    m_timer--;
    if (m_timer <= 0) begin
      if (m_mode != 2) m_dir = 0;
      m_mode = 1;
      m_blink = 0;
    end else if (m_mode == 2) m_blink = (m_timer <= 2);
  endtask

  // Returns 1 when the event changed mode state (and so swallows a coincident frame tick).
  function automatic bit m_events(input bit e, input bit f);
    if (pause) return 0;
    if (e && m_mode == 2) begin
      m_mode = 3; m_x = XC; m_y = YC; m_dir = 0; m_pend = 0; m_blink = 0; m_timer = 3;
      return 1;
    end
    if (f && (m_mode == 1 || m_mode == 2)) begin
      if (m_mode == 1) begin
        m_dir = (m_dir == 1) ? 2 : (m_dir == 2) ? 1 : (m_dir == 3) ? 4 : (m_dir == 4) ? 3 : 0;
        m_tog = 0;
      end
      m_mode = 2; m_timer = 6; m_blink = 0;
      return 1;
    end
    return 0;
  endfunction

  task automatic do_reset();
    @(negedge Clk) Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    m_reset();
    @(negedge Clk);
  endtask

  task automatic req_dir(input logic [7:0] code);
    @(negedge Clk) dir_code = code;
    @(negedge Clk) dir_code = 8'h00;
    if (!pause && key_dir(code) != 0) m_pend = key_dir(code);
  endtask

  task automatic tick_f(input string tag);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (6) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (6) @(negedge Clk);
    m_frame();
    check_all(tag);
  endtask

  task automatic tick_s(input string tag);
    @(negedge Clk) sec = 1'b1;
    repeat (6) @(negedge Clk);
    sec = 1'b0;
    repeat (6) @(negedge Clk);
    m_second();
    check_all(tag);
  endtask

  task automatic pulse_ev(input bit e, input bit f, input string tag);
    bit unused;
    @(negedge Clk) begin eaten = e; fright_req = f; end
    @(negedge Clk) begin eaten = 1'b0; fright_req = 1'b0; end
    @(negedge Clk);
    unused = m_events(e, f);
    check_all(tag);
  endtask

  // fright_req aligned to the very cycle the synchronised frame tick is consumed
  task automatic fright_on_tick(input string tag);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk) fright_req = 1'b1;
    @(negedge Clk) fright_req = 1'b0;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (6) @(negedge Clk);
    if (!m_events(1'b0, 1'b1)) m_frame();
    check_all(tag);
  endtask

  initial begin
    int guard;
    logic [7:0] codes [6];
    codes[0] = 8'h07; codes[1] = 8'h16; codes[2] = 8'h1A;
    codes[3] = 8'h04; codes[4] = 8'h00; codes[5] = 8'h55;

    m_reset();
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check_all("reset");
    chk("reset.x_const", 32'(ghostX), 32'd204);

    tick_s("home1");
    tick_s("release");
    chk("release.mode_const", 32'(mode), 32'd1);

    req_dir(8'h16);
    for (int i = 0; i < 5; i++) tick_f("roam_r");
    chk("roam_r.x209", 32'(ghostX), 32'd209);
    chk("roam_r.dir2", 32'(dir), 32'd2);

    mapT = 5'h04;
    req_dir(8'h04);
    for (int i = 0; i < 3; i++) tick_f("turn_blocked");
    chk("turn_blocked.dirR", 32'(dir), 32'd2);
    mapT = '0;
    tick_f("turn_up");
    chk("turn_up.dirU", 32'(dir), 32'd4);
    chk("turn_up.y79", 32'(ghostY), 32'd79);

    req_dir(8'h1A);
    guard = 0;
    while (m_y < 200 && guard < 400) begin tick_f("route_d"); guard++; end
    req_dir(8'h07);
    guard = 0;
    while (m_x > 11 && guard < 400) begin tick_f("route_l"); guard++; end
    chk("route.at11", 32'(ghostX), 32'd11);
    tick_f("tunnel_step");
    chk("tunnel_step.x10", 32'(ghostX), 32'd10);
    tick_f("tunnel_wrap");
    chk("tunnel_wrap.x385", 32'(ghostX), 32'd385);
    chk("tunnel_wrap.dirL", 32'(dir), 32'd1);

    req_dir(8'h16);
    tick_f("pre_fright");
    pulse_ev(1'b0, 1'b1, "fright_enter");
    chk("fright_enter.dirL", 32'(dir), 32'd1);
    for (int i = 0; i < 8; i++) tick_f("fright_half");
    chk("fright_half.x382", 32'(ghostX), 32'd382);
    for (int i = 0; i < 4; i++) tick_s("fright_sec");
    chk("fright.blink_on", 32'(blink), 32'd1);
    pulse_ev(1'b0, 1'b1, "fright_restart");
    chk("fright_restart.dir_kept", 32'(dir), 32'd1);
    for (int i = 0; i < 6; i++) tick_s("fright_end");
    chk("fright_end.roam", 32'(mode), 32'd1);

    req_dir(8'h16);
    tick_f("roam_again");
    fright_on_tick("fright_vs_tick");
    pulse_ev(1'b1, 1'b1, "eaten_wins");
    chk("eaten_wins.x", 32'(ghostX), 32'd204);
    for (int i = 0; i < 3; i++) tick_s("respawn");
    chk("respawn.roam", 32'(mode), 32'd1);

    pulse_ev(1'b0, 1'b1, "fright2");
    pause = 1'b1;
    req_dir(8'h1A);
    tick_f("paused_f");
    tick_s("paused_s");
    pulse_ev(1'b1, 1'b0, "paused_eat");
    pause = 1'b0;
    pulse_ev(1'b1, 1'b0, "eat2");
    tick_s("respawn_mid");
    do_reset();
    check_all("reset_mid_respawn");
    chk("reset_mid.home", 32'(mode), 32'd0);
    tick_s("home_again1");
    tick_s("home_again2");

    for (int n = 0; n < 250; n++) begin
      int ev;
      ev = int'($urandom_range(0, 19));
      if (ev <= 9) begin
        mapL = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : '0;
        mapR = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : '0;
        mapB = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : '0;
        mapT = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : '0;
        if ($urandom_range(0, 2) == 0) req_dir(codes[$urandom_range(0, 5)]);
        tick_f("rnd_move");
      end else if (ev <= 11) tick_s("rnd_sec");
      else if (ev == 12) pulse_ev(1'b0, 1'b1, "rnd_fright");
      else if (ev == 13) pulse_ev(1'b1, 1'b0, "rnd_eat");
      else if (ev == 14) pulse_ev(1'b1, 1'b1, "rnd_both");
      else if (ev <= 16) begin
        pause = 1'b1;
        req_dir(codes[$urandom_range(0, 5)]);
        tick_f("rnd_paused");
        pause = 1'b0;
      end else if (ev == 17) fright_on_tick("rnd_fright_tick");
      else req_dir(codes[$urandom_range(0, 5)]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
